// File: rtl/joy_pkg.sv
// ---------------------------------------------------------------------------
// joy_pkg
// Shared constants for the Kempston joystick block:
//   - K_* : bit positions of each control in the Kempston byte
//   - KEMPSTON_PORT_DEFAULT : low address byte answered on I/O reads
//   - TURBO_W : width of the frame counter behind the turbo strobe
//   - cancel_opposing() : drops physically impossible direction pairs
// ---------------------------------------------------------------------------
package joy_pkg;

    localparam int K_RIGHT = 0;
    localparam int K_LEFT  = 1;
    localparam int K_DOWN  = 2;
    localparam int K_UP    = 3;
    localparam int K_B1    = 4;
    localparam int K_B2    = 5;
    localparam int K_B3    = 6;
    localparam int K_START = 7;

    localparam logic [7:0] KEMPSTON_PORT_DEFAULT = 8'h1F;

    // Enough for a TURBO_DIV of up to 15 frames per half-period.
    localparam int TURBO_W = 4;

    // A worn pad or a chorded tap can report left+right (or up+down) in the
    // same frame; games misbehave on that, so such a pair reads as neither.
    function automatic logic [7:0] cancel_opposing(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[K_LEFT] && v[K_RIGHT]) begin
            r[K_LEFT]  = 1'b0;
            r[K_RIGHT] = 1'b0;
        end
        if (v[K_UP] && v[K_DOWN]) begin
            r[K_UP]   = 1'b0;
            r[K_DOWN] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/joy_kempston_if.sv
// ---------------------------------------------------------------------------
// joy_kempston_if
// Z80 I/O read path as seen by the Kempston block.
//   bus_addr     : Z80 A[7:0]                       (master -> slave)
//   bus_rd       : synchronised IORQ & RD level     (master -> slave)
//   d_out        : Kempston byte, 0 when not read   (slave -> master)
//   d_out_active : slave is driving the data bus    (slave -> master)
// ---------------------------------------------------------------------------
interface joy_kempston_if;

    logic [7:0] bus_addr;
    logic       bus_rd;
    logic [7:0] d_out;
    logic       d_out_active;

    modport master (
        output bus_addr,
        output bus_rd,
        input  d_out,
        input  d_out_active
    );

    modport slave (
        input  bus_addr,
        input  bus_rd,
        output d_out,
        output d_out_active
    );

endinterface

// File: rtl/joy_turbo_gen.sv
// ---------------------------------------------------------------------------
// joy_turbo_gen
// Derives a single-cycle frame tick from the video counters and divides it
// down into the autofire square wave.
//   clk28, rst      : system clock, synchronous active-high reset
//   vc, hc          : vertical / horizontal frame position
//   tick            : one clk28 pulse at the start of every frame
//   turbo_strobe    : toggles every TURBO_DIV frames
// ---------------------------------------------------------------------------
module joy_turbo_gen
    import joy_pkg::*;
#(
    parameter int TURBO_DIV = 2
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic [8:0] vc,
    input  logic [8:0] hc,
    output logic       tick,
    output logic       turbo_strobe
);

    localparam logic [TURBO_W-1:0] DIV_LAST = TURBO_W'(TURBO_DIV - 1);

    logic               frame_cond;
    logic               frame_cond_q;
    logic [TURBO_W-1:0] cnt_q,    cnt_d;
    logic               strobe_q, strobe_d;

    // The counters sit at (0,0) for a whole pixel-clock period, which spans
    // several clk28 cycles; the edge detect keeps it to one tick per frame.
    always_comb begin
        frame_cond = (vc == 9'd0) && (hc == 9'd0);
        tick       = frame_cond & ~frame_cond_q;
    end

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        strobe_d = strobe_q;
        if (tick) begin
            if (cnt_q == DIV_LAST) begin
                cnt_d    = '0;
                strobe_d = ~strobe_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk28) begin
        if (rst) begin
            frame_cond_q <= 1'b0;
            cnt_q        <= '0;
            strobe_q     <= 1'b0;
        end else begin
            frame_cond_q <= frame_cond;
            cnt_q        <= cnt_d;
            strobe_q     <= strobe_d;
        end
    end

    assign turbo_strobe = strobe_q;

endmodule

// File: rtl/joy_kempston.sv
// ---------------------------------------------------------------------------
// joy_kempston
// Turns the pad scanner's decoded button levels into a Kempston joystick
// port. Presses are OR-accumulated over each video frame so a tap shorter
// than a frame still shows up, and the CPU reads a per-frame snapshot.
//   clk28, rst          : 28 MHz clock, synchronous active-high reset
//   vc, hc              : frame position from the video timing
//   joy_*               : decoded pad levels, active-high
//   turbo_strobe        : autofire square wave back to the scanner
//   bus (slave modport) : bus_addr/bus_rd in, d_out/d_out_active out
// ---------------------------------------------------------------------------
module joy_kempston
    import joy_pkg::*;
#(
    parameter int         TURBO_DIV     = 2,
    parameter logic [7:0] KEMPSTON_PORT = KEMPSTON_PORT_DEFAULT
) (
    input  logic            clk28,
    input  logic            rst,
    input  logic [8:0]      vc,
    input  logic [8:0]      hc,
    input  logic            joy_up,
    input  logic            joy_down,
    input  logic            joy_left,
    input  logic            joy_right,
    input  logic            joy_b1_turbo,
    input  logic            joy_b2_turbo,
    input  logic            joy_b3_turbo,
    input  logic            joy_start,
    output logic            turbo_strobe,
    joy_kempston_if.slave   bus
);

    logic       tick;
    logic       hit;
    logic [7:0] live;
    logic [7:0] sticky_q,   sticky_d;
    logic [7:0] snapshot_q, snapshot_d;
    logic [7:0] d_out_q,    d_out_d;
    logic       active_q,   active_d;

    joy_turbo_gen #(
        .TURBO_DIV    (TURBO_DIV)
    ) u_turbo_gen (
        .clk28        (clk28),
        .rst          (rst),
        .vc           (vc),
        .hc           (hc),
        .tick         (tick),
        .turbo_strobe (turbo_strobe)
    );

    always_comb begin
        live          = '0;
        live[K_RIGHT] = joy_right;
        live[K_LEFT]  = joy_left;
        live[K_DOWN]  = joy_down;
        live[K_UP]    = joy_up;
        live[K_B1]    = joy_b1_turbo;
        live[K_B2]    = joy_b2_turbo;
        live[K_B3]    = joy_b3_turbo;
        live[K_START] = joy_start;
    end

    always_comb begin
        sticky_d   = sticky_q;
        snapshot_d = snapshot_q;
        hit        = bus.bus_rd && (bus.bus_addr == KEMPSTON_PORT);

        // The tick-cycle press goes into this frame's snapshot only; the
        // accumulator restarts empty so it is not counted twice.
        if (tick) begin
            snapshot_d = cancel_opposing(sticky_q | live);
            sticky_d   = '0;
        end else begin
            sticky_d   = sticky_q | live;
        end

        // Reads never touch the accumulator, and no value is held for the
        // duration of a read: a tick mid-read shows the new snapshot.
        d_out_d  = hit ? snapshot_q : 8'h00;
        active_d = hit;
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            sticky_q   <= '0;
            snapshot_q <= '0;
            d_out_q    <= '0;
            active_q   <= 1'b0;
        end else begin
            sticky_q   <= sticky_d;
            snapshot_q <= snapshot_d;
            d_out_q    <= d_out_d;
            active_q   <= active_d;
        end
    end

    assign bus.d_out        = d_out_q;
    assign bus.d_out_active = active_q;

endmodule

// File: tb/tb_joy_kempston.sv
// ---------------------------------------------------------------------------
// tb_joy_kempston
// Directed scenarios followed by a randomized run. A frame-level reference
// model (presses OR-ed per frame, tick count for autofire) predicts the
// registered bus outputs and turbo_strobe every cycle.
// ---------------------------------------------------------------------------
module tb_joy_kempston;

    localparam int         TDIV = 2;
    localparam logic [7:0] PORT = 8'h1F;
    localparam int         HMAX = 16;   // shortened frame: 16 x 4 positions
    localparam int         VMAX = 4;

    logic       clk28 = 1'b0;
    logic       rst;
    logic [8:0] vc;
    logic [8:0] hc;
    logic [7:0] btn;
    logic       joy_up, joy_down, joy_left, joy_right;
    logic       joy_b1_turbo, joy_b2_turbo, joy_b3_turbo, joy_start;
    logic       turbo_strobe;

    always #5 clk28 = ~clk28;

    assign joy_right    = btn[0];
    assign joy_left     = btn[1];
    assign joy_down     = btn[2];
    assign joy_up       = btn[3];
    assign joy_b1_turbo = btn[4];
    assign joy_b2_turbo = btn[5];
    assign joy_b3_turbo = btn[6];
    assign joy_start    = btn[7];

    joy_kempston_if bus_if ();

    joy_kempston #(
        .TURBO_DIV     (TDIV),
        .KEMPSTON_PORT (PORT)
    ) dut (
        .clk28         (clk28),
        .rst           (rst),
        .vc            (vc),
        .hc            (hc),
        .joy_up        (joy_up),
        .joy_down      (joy_down),
        .joy_left      (joy_left),
        .joy_right     (joy_right),
        .joy_b1_turbo  (joy_b1_turbo),
        .joy_b2_turbo  (joy_b2_turbo),
        .joy_b3_turbo  (joy_b3_turbo),
        .joy_start     (joy_start),
        .turbo_strobe  (turbo_strobe),
        .bus           (bus_if.slave)
    );

    int total = 0;
    int bad   = 0;
    int frame_num = 0;
    bit hold_en = 1'b0;

    // Reference model state
    logic [7:0] m_pressed;     // everything seen in the current frame
    logic [7:0] m_snap;
    logic [7:0] m_dout;
    logic       m_act;
    int         m_ticks;       // frame starts seen since reset
    logic       m_at_origin;   // position was (0,0) on the previous edge

    function automatic logic [7:0] resolve(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if ((r & 8'h03) == 8'h03) r = r & 8'hFC;
        if ((r & 8'h0C) == 8'h0C) r = r & 8'hF3;
        return r;
    endfunction

    function automatic logic m_strobe();
        return ((m_ticks / TDIV) % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pressed   = '0;
        m_snap      = '0;
        m_dout      = '0;
        m_act       = 1'b0;
        m_ticks     = 0;
        m_at_origin = 1'b0;
    endtask

    task automatic advance_pos();
        if (hold_en && ($urandom_range(0, 3) == 0)) return;
        if (hc == 9'(HMAX - 1)) begin
            hc = '0;
            vc = (vc == 9'(VMAX - 1)) ? 9'd0 : vc + 9'd1;
        end else begin
            hc = hc + 9'd1;
        end
        if (vc == 9'd0 && hc == 9'd0) frame_num++;
    endtask

    // One clock: the model consumes the inputs present at the edge, the
    // outputs are compared 1 ns later, then the position moves on.
    task automatic cycle();
        logic origin;
        logic starts_frame;
        logic hit;
        @(posedge clk28);
        if (rst) begin
            model_reset();
        end else begin
            origin       = (vc == 9'd0) && (hc == 9'd0);
            starts_frame = origin && !m_at_origin;
            m_at_origin  = origin;
            hit          = bus_if.bus_rd && (bus_if.bus_addr == PORT);
            m_dout       = hit ? m_snap : 8'h00;
            m_act        = hit;
            if (starts_frame) begin
                m_snap    = resolve(m_pressed | btn);
                m_pressed = '0;
                m_ticks++;
            end else begin
                m_pressed = m_pressed | btn;
            end
        end
        #1;
        check("d_out", bus_if.d_out, m_dout);
        check("d_out_active", {7'd0, bus_if.d_out_active}, {7'd0, m_act});
        check("turbo_strobe", {7'd0, turbo_strobe}, {7'd0, m_strobe()});
        advance_pos();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Runs until the position has just wrapped to (0,0); the next edge is
    // the frame tick.
    task automatic next_frame();
        int start;
        int budget;
        start  = frame_num;
        budget = 0;
        while (frame_num == start && budget < 1000) begin
            cycle();
            budget++;
        end
        check("frame_wrap_within_budget", {7'd0, frame_num != start}, 8'h01);
    endtask

    task automatic read_port(input logic [7:0] addr);
        bus_if.bus_rd   = 1'b1;
        bus_if.bus_addr = addr;
        cycle();
    endtask

    logic [7:0] turbo_pat;
    int         r;

    initial begin
        rst             = 1'b1;
        btn             = '0;
        vc              = '0;
        hc              = '0;
        bus_if.bus_rd   = 1'b0;
        bus_if.bus_addr = '0;
        model_reset();

        // ---- reset ----
        cycles(3);
        check("reset_d_out", bus_if.d_out, 8'h00);
        check("reset_active", {7'd0, bus_if.d_out_active}, 8'h00);
        check("reset_turbo", {7'd0, turbo_strobe}, 8'h00);
        rst = 1'b0;
        vc  = 9'(VMAX - 1);
        hc  = 9'(HMAX - 1);

        // ---- turbo timing: strobe seen just before each frame's tick ----
        hold_en   = 1'b1;
        turbo_pat = 8'hCC;   // frames 0..7 -> 0,0,1,1,0,0,1,1
        for (int f = 0; f < 8; f++) begin
            next_frame();
            check($sformatf("turbo_frame%0d", f), {7'd0, turbo_strobe}, {7'd0, turbo_pat[f]});
        end

        // ---- short tap of b1 ----
        next_frame();
        cycles(5);
        btn = 8'h10;
        cycle();
        btn = 8'h00;
        next_frame();
        cycles(3);
        read_port(PORT);
        check("tap_read", bus_if.d_out, 8'h10);
        check("tap_active", {7'd0, bus_if.d_out_active}, 8'h01);
        bus_if.bus_rd = 1'b0;
        cycle();
        next_frame();
        cycles(3);
        read_port(PORT);
        check("tap_gone", bus_if.d_out, 8'h00);
        bus_if.bus_rd = 1'b0;

        // ---- opposing directions ----
        btn = 8'h0B;         // up + left + right
        next_frame();
        cycles(3);
        read_port(PORT);
        check("opposing_lr", bus_if.d_out, 8'h08);
        bus_if.bus_rd = 1'b0;

        // ---- address decode, up held ----
        btn = 8'h08;
        next_frame();
        cycles(3);
        read_port(8'h1E);
        check("decode_miss_data", bus_if.d_out, 8'h00);
        check("decode_miss_active", {7'd0, bus_if.d_out_active}, 8'h00);
        read_port(PORT);
        check("decode_hit_data", bus_if.d_out, 8'h08);
        check("decode_hit_active", {7'd0, bus_if.d_out_active}, 8'h01);
        bus_if.bus_rd = 1'b0;
        cycle();
        check("decode_active_drop", {7'd0, bus_if.d_out_active}, 8'h00);

        // ---- press only on the tick cycle ----
        btn = 8'h00;
        next_frame();
        next_frame();
        btn = 8'h80;
        cycle();
        btn = 8'h00;
        cycles(3);
        read_port(PORT);
        check("tick_press_read", bus_if.d_out, 8'h80);
        bus_if.bus_rd = 1'b0;
        next_frame();
        cycles(3);
        read_port(PORT);
        check("tick_press_cleared", bus_if.d_out, 8'h00);
        bus_if.bus_rd = 1'b0;

        // ---- reset while accumulating with turbo high ----
        btn = 8'h3F;
        for (int k = 0; k < 4 && !m_strobe(); k++) begin
            next_frame();
            cycles(3);
        end
        cycles(2);
        check("pre_reset_turbo_high", {7'd0, turbo_strobe}, 8'h01);
        read_port(PORT);
        check("pre_reset_snapshot", bus_if.d_out, 8'h30);
        rst = 1'b1;
        btn = 8'h00;
        cycle();
        check("midreset_turbo", {7'd0, turbo_strobe}, 8'h00);
        check("midreset_d_out", bus_if.d_out, 8'h00);
        check("midreset_active", {7'd0, bus_if.d_out_active}, 8'h00);
        rst           = 1'b0;
        bus_if.bus_rd = 1'b0;
        next_frame();
        cycles(3);
        read_port(PORT);
        check("post_reset_snapshot", bus_if.d_out, 8'h00);
        bus_if.bus_rd = 1'b0;

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            btn           = 8'($urandom & $urandom & $urandom & $urandom);
            bus_if.bus_rd = 1'($urandom_range(0, 1));
            r             = int'($urandom_range(0, 3));
            case (r)
                0, 1:    bus_if.bus_addr = PORT;
                2:       bus_if.bus_addr = 8'h1E;
                default: bus_if.bus_addr = 8'($urandom);
            endcase
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
